// File: rtl/ploc_occupancy_counter.sv
// Parking-lot occupancy counter.
// Turns entry/exit event codes into a bounded occupancy count with full and
// empty status. Faults go to sticky flags and a saturating error counter.
// A background double-dabble converter drives three BCD digits for display.
//
// Handshake: there is no valid/ready pair. An event code acts exactly once,
// in the first cycle it differs from the previous cycle's code, and only if
// it is not IDLE. bcd_busy high means bcd_hund/tens/ones still hold the
// previous result. A new result is guaranteed to follow.
module ploc_occupancy_counter #(
   parameter int CAPACITY = 25,
   parameter int CNT_W    = 10,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       inc_dec,
   input  logic             clr_err,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             ovf_err,
   output logic             unf_err,
   output logic             sensor_fault,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       bcd_hund,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic             bcd_busy
);

   localparam logic [1:0]       CODE_IDLE = 2'b00;
   localparam logic [1:0]       CODE_DEC  = 2'b01;
   localparam logic [1:0]       CODE_INC  = 2'b10;
   localparam logic [1:0]       CODE_ERR  = 2'b11;
   localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;
   localparam int               SH_W      = $clog2(CNT_W + 1);
   localparam int               WORK_W    = 12 + CNT_W;
   localparam logic [SH_W-1:0]  LAST_SH   = SH_W'(CNT_W - 1);

   // Converter state is kept in a named enum register so checkers can bind to it.
   typedef enum logic [1:0] {
      BCD_IDLE  = 2'b00,
      BCD_SHIFT = 2'b01,
      BCD_DONE  = 2'b10
   } bcd_state_t;

   logic [1:0]        prev_code;
   logic              event_act;
   logic              inc_ev;
   logic              dec_ev;
   logic              err_code_ev;
   logic              ovf_ev;
   logic              unf_ev;
   logic              any_err_ev;
   logic [CNT_W-1:0]  count_q;
   logic              count_chg_q;
   logic              pending_q;
   bcd_state_t        bcd_state_q;
   bcd_state_t        bcd_state_d;
   logic              conv_start;
   logic [SH_W-1:0]   shift_cnt_q;
   logic [WORK_W-1:0] work_q;
   logic [WORK_W-1:0] work_adj;
   logic [11:0]       bcd_q;

   // Edge-detect the event code: only a fresh, non-IDLE code counts.
   assign event_act   = (inc_dec != CODE_IDLE) && (inc_dec != prev_code);
   assign inc_ev      = event_act && (inc_dec == CODE_INC);
   assign dec_ev      = event_act && (inc_dec == CODE_DEC);
   assign err_code_ev = event_act && (inc_dec == CODE_ERR);

   assign full        = (count_q == CAP_VAL);
   assign empty       = (count_q == '0);
   assign ovf_ev      = inc_ev && full;
   assign unf_ev      = dec_ev && empty;
   assign any_err_ev  = ovf_ev || unf_ev || err_code_ev;

   assign count       = count_q;
   assign bcd_hund    = bcd_q[11:8];
   assign bcd_tens    = bcd_q[7:4];
   assign bcd_ones    = bcd_q[3:0];
   assign bcd_busy    = (bcd_state_q != BCD_IDLE);
   assign conv_start  = (bcd_state_q == BCD_IDLE) && (count_chg_q || pending_q);

   // Remember last cycle's code for event qualification.
   always_ff @(posedge clk) begin
      if (reset) prev_code <= CODE_IDLE;
      else       prev_code <= inc_dec;
   end

   // Occupancy register: bounded up/down count, never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         count_chg_q <= 1'b0;
      end else begin
         count_chg_q <= 1'b0;
         if (inc_ev && !full) begin
            count_q     <= count_q + CNT_W'(1);
            count_chg_q <= 1'b1;
         end else if (dec_ev && !empty) begin
            count_q     <= count_q - CNT_W'(1);
            count_chg_q <= 1'b1;
         end
      end
   end

   // Sticky fault flags and saturating error count; a clear strobe is applied before a same-cycle event.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_err      <= 1'b0;
         unf_err      <= 1'b0;
         sensor_fault <= 1'b0;
         err_cnt      <= '0;
      end else begin
         if (clr_err) begin
            ovf_err      <= 1'b0;
            unf_err      <= 1'b0;
            sensor_fault <= 1'b0;
            err_cnt      <= '0;
         end
         if (ovf_ev)      ovf_err      <= 1'b1;
         if (unf_ev)      unf_err      <= 1'b1;
         if (err_code_ev) sensor_fault <= 1'b1;
         if (any_err_ev) begin
            if (clr_err)                err_cnt <= ERR_W'(1);
            else if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
         end
      end
   end

   // Converter state register.
   always_ff @(posedge clk) begin
      if (reset) bcd_state_q <= BCD_IDLE;
      else       bcd_state_q <= bcd_state_d;
   end

   // Converter next-state: start on a count change or a deferred request, shift CNT_W bits, then publish.
   always_comb begin
      bcd_state_d = bcd_state_q;
      case (bcd_state_q)
         BCD_IDLE:  if (conv_start) bcd_state_d = BCD_SHIFT;
         BCD_SHIFT: if (shift_cnt_q == LAST_SH) bcd_state_d = BCD_DONE;
         BCD_DONE:  bcd_state_d = BCD_IDLE;
         default:   bcd_state_d = BCD_IDLE;
      endcase
   end

   // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
   always_comb begin
      work_adj = work_q;
      for (int i = 0; i < 3; i++) begin
         if (work_q[CNT_W + 4*i +: 4] >= 4'd5)
            work_adj[CNT_W + 4*i +: 4] = work_q[CNT_W + 4*i +: 4] + 4'd3;
      end
   end

   // Converter datapath: load, shift and publish, plus the pending flag for changes seen while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         work_q      <= '0;
         shift_cnt_q <= '0;
         pending_q   <= 1'b0;
         bcd_q       <= '0;
      end else begin
         if (conv_start)
            pending_q <= 1'b0;
         else if (count_chg_q && (bcd_state_q != BCD_IDLE))
            pending_q <= 1'b1;

         case (bcd_state_q)
            BCD_IDLE: begin
               if (conv_start) begin
                  work_q      <= {12'b0, count_q};
                  shift_cnt_q <= '0;
               end
            end
            BCD_SHIFT: begin
               work_q      <= {work_adj[WORK_W-2:0], 1'b0};
               shift_cnt_q <= shift_cnt_q + SH_W'(1);
            end
            BCD_DONE: begin
               bcd_q <= work_q[WORK_W-1:CNT_W];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ploc_occupancy_counter.sv
// Bench for the parking-lot occupancy counter.
// A reference model of count, flags and err_cnt is built from the event rules.
// Expected BCD digits come from plain integer division of the model count.
module tb_ploc_occupancy_counter;

   localparam int CAPACITY = 25;
   localparam int CNT_W    = 10;
   localparam int ERR_W    = 8;
   localparam int ERR_MAX  = 255;

   localparam logic [1:0] C_IDLE = 2'b00;
   localparam logic [1:0] C_DEC  = 2'b01;
   localparam logic [1:0] C_INC  = 2'b10;
   localparam logic [1:0] C_ERR  = 2'b11;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       inc_dec = 2'b00;
   logic             clr_err = 1'b0;
   logic [CNT_W-1:0] count;
   logic             full, empty, ovf_err, unf_err, sensor_fault, bcd_busy;
   logic [ERR_W-1:0] err_cnt;
   logic [3:0]       bcd_hund, bcd_tens, bcd_ones;

   always #5 clk = ~clk;

   ploc_occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset), .inc_dec(inc_dec), .clr_err(clr_err),
      .count(count), .full(full), .empty(empty),
      .ovf_err(ovf_err), .unf_err(unf_err), .sensor_fault(sensor_fault),
      .err_cnt(err_cnt), .bcd_hund(bcd_hund), .bcd_tens(bcd_tens),
      .bcd_ones(bcd_ones), .bcd_busy(bcd_busy)
   );

   // ---------------- reference model ----------------
   int         m_count;
   logic [1:0] m_prev;
   logic       m_ovf, m_unf, m_sf;
   int         m_err;
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic logic [11:0] exp_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int bump(input int e);
      return (e < ERR_MAX) ? e + 1 : e;
   endfunction

   // ---------------- driver tasks ----------------
   // Apply one cycle of stimulus and advance the model with the same edge.
   task automatic drive(input logic [1:0] code, input logic clr);
      bit ev;
      inc_dec = code;
      clr_err = clr;
      @(posedge clk);
      if (reset) begin
         m_count = 0; m_prev = C_IDLE; m_ovf = 0; m_unf = 0; m_sf = 0; m_err = 0;
      end else begin
         ev = (code != C_IDLE) && (code != m_prev);
         m_prev = code;
         if (clr) begin
            m_ovf = 0; m_unf = 0; m_sf = 0; m_err = 0;
         end
         if (ev) begin
            case (code)
               C_INC: if (m_count < CAPACITY) m_count++; else begin m_ovf = 1; m_err = bump(m_err); end
               C_DEC: if (m_count > 0) m_count--; else begin m_unf = 1; m_err = bump(m_err); end
               default: begin m_sf = 1; m_err = bump(m_err); end
            endcase
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(C_IDLE, 1'b0);
      drive(C_IDLE, 1'b0);
      reset = 1'b0;
   endtask

   // Idle long enough for any running plus deferred conversion, then wait (bounded) for idle.
   task automatic settle(output bit ok);
      repeat (2*CNT_W + 8) drive(C_IDLE, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!bcd_busy) begin
            ok = 1'b1;
            break;
         end
         drive(C_IDLE, 1'b0);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++;
      if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++;
      if ({full, empty} !== 2'b01) begin n_fail++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
      n_checks++;
      if ({ovf_err, unf_err, sensor_fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {ovf_err, unf_err, sensor_fault}); end
      n_checks++;
      if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
      n_checks++;
      if ({bcd_busy, bcd_hund, bcd_tens, bcd_ones} !== 13'h0) begin n_fail++; $display("FAIL reset_bcd: got busy=%b %h%h%h expected busy=0 000", bcd_busy, bcd_hund, bcd_tens, bcd_ones); end
   endtask

   task automatic test_isolated_inc();
      do_reset();
      repeat (2) begin
         drive(C_INC, 1'b0);
         repeat (15) drive(C_IDLE, 1'b0);
      end
      drive(C_INC, 1'b0);
      repeat (CNT_W + 1) drive(C_IDLE, 1'b0);
      n_checks++;
      if ({bcd_busy, bcd_hund, bcd_tens, bcd_ones} !== {1'b1, 12'h002}) begin n_fail++; $display("FAIL bcd_latency_hold: got busy=%b %h%h%h expected busy=1 002", bcd_busy, bcd_hund, bcd_tens, bcd_ones); end
      drive(C_IDLE, 1'b0);
      n_checks++;
      if ({bcd_busy, bcd_hund, bcd_tens, bcd_ones} !== {1'b0, 12'h003}) begin n_fail++; $display("FAIL bcd_latency_new: got busy=%b %h%h%h expected busy=0 003", bcd_busy, bcd_hund, bcd_tens, bcd_ones); end
      n_checks++;
      if (count !== 10'd3 || m_count != 3) begin n_fail++; $display("FAIL isolated_inc_count: got %0d expected 3 (model %0d)", count, m_count); end
   endtask

   task automatic test_held_inc();
      int base;
      base = m_count;
      repeat (5) drive(C_INC, 1'b0);
      drive(C_IDLE, 1'b0);
      n_checks++;
      if (count !== CNT_W'(base + 1)) begin n_fail++; $display("FAIL held_inc: got %0d expected %0d", count, base + 1); end
      drive(C_INC, 1'b0);
      drive(C_IDLE, 1'b0);
      drive(C_INC, 1'b0);
      drive(C_IDLE, 1'b0);
      n_checks++;
      if (count !== CNT_W'(base + 3)) begin n_fail++; $display("FAIL back_to_back_inc: got %0d expected %0d", count, base + 3); end
   endtask

   task automatic test_fill_overflow();
      bit ok;
      do_reset();
      repeat (CAPACITY) begin
         drive(C_INC, 1'b0);
         drive(C_IDLE, 1'b0);
      end
      n_checks++;
      if ({count, full, ovf_err} !== {CNT_W'(CAPACITY), 1'b1, 1'b0}) begin n_fail++; $display("FAIL fill_to_cap: got count=%0d full=%b ovf=%b expected 25 1 0", count, full, ovf_err); end
      drive(C_INC, 1'b0);
      drive(C_IDLE, 1'b0);
      n_checks++;
      if ({count, full, ovf_err, err_cnt} !== {CNT_W'(CAPACITY), 1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL overflow: got count=%0d full=%b ovf=%b err=%0d expected 25 1 1 1", count, full, ovf_err, err_cnt); end
      settle(ok);
      n_checks++;
      if (!ok || {bcd_hund, bcd_tens, bcd_ones} !== 12'h025) begin n_fail++; $display("FAIL bcd_full: got settled=%b %h%h%h expected 1 025", ok, bcd_hund, bcd_tens, bcd_ones); end
   endtask

   task automatic test_underflow_clear();
      do_reset();
      drive(C_DEC, 1'b0);
      drive(C_IDLE, 1'b0);
      n_checks++;
      if ({count, empty, unf_err, err_cnt} !== {10'd0, 1'b1, 1'b1, 8'd1}) begin n_fail++; $display("FAIL underflow: got count=%0d empty=%b unf=%b err=%0d expected 0 1 1 1", count, empty, unf_err, err_cnt); end
      drive(C_ERR, 1'b0);
      drive(C_IDLE, 1'b0);
      n_checks++;
      if ({sensor_fault, err_cnt} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL sensor_err: got sf=%b err=%0d expected 1 2", sensor_fault, err_cnt); end
      drive(C_ERR, 1'b1);
      n_checks++;
      if ({ovf_err, unf_err, sensor_fault, err_cnt} !== {3'b001, 8'd1}) begin n_fail++; $display("FAIL clr_with_err: got ovf=%b unf=%b sf=%b err=%0d expected 0 0 1 1", ovf_err, unf_err, sensor_fault, err_cnt); end
      drive(C_IDLE, 1'b1);
      n_checks++;
      if ({ovf_err, unf_err, sensor_fault, err_cnt} !== {3'b000, 8'd0}) begin n_fail++; $display("FAIL clr_alone: got ovf=%b unf=%b sf=%b err=%0d expected 0 0 0 0", ovf_err, unf_err, sensor_fault, err_cnt); end
   endtask

   task automatic test_err_saturation();
      do_reset();
      repeat (300) begin
         drive(C_ERR, 1'b0);
         drive(C_IDLE, 1'b0);
      end
      n_checks++;
      if (err_cnt !== 8'd255 || m_err != 255) begin n_fail++; $display("FAIL err_saturate: got %0d expected 255 (model %0d)", err_cnt, m_err); end
      n_checks++;
      if (count !== '0) begin n_fail++; $display("FAIL err_no_count: got %0d expected 0", count); end
   endtask

   task automatic test_random();
      int  r;
      bit  ok;
      logic [1:0] code;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         code = (r < 4) ? C_INC : (r < 7) ? C_DEC : (r == 7) ? C_ERR : C_IDLE;
         drive(code, ($urandom_range(0, 15) == 0));
         n_checks++;
         if ({count, full, empty, ovf_err, unf_err, sensor_fault, err_cnt} !==
             {CNT_W'(m_count), (m_count == CAPACITY), (m_count == 0), m_ovf, m_unf, m_sf, ERR_W'(m_err)}) begin
            n_fail++;
            $display("FAIL random_cycle_%0d: got count=%0d f=%b e=%b ovf=%b unf=%b sf=%b err=%0d expected count=%0d ovf=%b unf=%b sf=%b err=%0d",
                     i, count, full, empty, ovf_err, unf_err, sensor_fault, err_cnt, m_count, m_ovf, m_unf, m_sf, m_err);
         end
      end
      settle(ok);
      n_checks++;
      if (!ok || {bcd_hund, bcd_tens, bcd_ones} !== exp_bcd(m_count)) begin n_fail++; $display("FAIL random_bcd: got settled=%b %h%h%h expected %h", ok, bcd_hund, bcd_tens, bcd_ones, exp_bcd(m_count)); end
   endtask

   task automatic test_conversion_overlap();
      bit ok;
      bit saw_busy;
      do_reset();
      saw_busy = 1'b0;
      repeat (20) begin
         drive(C_INC, 1'b0);
         saw_busy |= bcd_busy;
         drive(C_IDLE, 1'b0);
         saw_busy |= bcd_busy;
         drive(C_IDLE, 1'b0);
      end
      n_checks++;
      if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL overlap_busy: got %b expected 1", saw_busy); end
      settle(ok);
      n_checks++;
      if (!ok || {count, bcd_hund, bcd_tens, bcd_ones} !== {10'd20, 12'h020}) begin n_fail++; $display("FAIL overlap_final_bcd: got settled=%b count=%0d %h%h%h expected 1 20 020", ok, count, bcd_hund, bcd_tens, bcd_ones); end
   endtask

   task automatic test_reset_mid_shift();
      drive(C_INC, 1'b0);
      repeat (4) drive(C_IDLE, 1'b0);
      n_checks++;
      if (bcd_busy !== 1'b1) begin n_fail++; $display("FAIL mid_shift_busy: got %b expected 1", bcd_busy); end
      reset = 1'b1;
      drive(C_IDLE, 1'b0);
      reset = 1'b0;
      n_checks++;
      if ({bcd_busy, bcd_hund, bcd_tens, bcd_ones, count} !== {1'b0, 12'h000, 10'd0}) begin n_fail++; $display("FAIL reset_mid_shift: got busy=%b %h%h%h count=%0d expected 0 000 0", bcd_busy, bcd_hund, bcd_tens, bcd_ones, count); end
      repeat (CNT_W + 4) drive(C_IDLE, 1'b0);
      n_checks++;
      if ({bcd_busy, bcd_hund, bcd_tens, bcd_ones} !== 13'h0) begin n_fail++; $display("FAIL post_reset_quiet: got busy=%b %h%h%h expected 0 000", bcd_busy, bcd_hund, bcd_tens, bcd_ones); end
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      test_reset();
      test_isolated_inc();
      test_held_inc();
      test_fill_overflow();
      test_underflow_clear();
      test_err_saturation();
      test_random();
      test_conversion_overlap();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
